snoop_responder: RTL

- Bus-side snoop responder for the L2. Accepts one snooped bus operation at a time from other processors: READ, WRITE, INVALIDATE or RWIM.
- Looks the operation up in the external L2 tag/MESI store and returns NOHIT/HIT/HITM.
- On a hit, drives GETLINE/INVALIDATELINE messages to L1, writes back modified lines, and updates MESI state.
- It is the responding end of the bus protocol whose operations our L2 initiates.

---
 rtl/snoop_responder_pkg.sv | 18 +
 rtl/snoop_way_match.sv | 31 +++
 rtl/snoop_responder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/snoop_responder_pkg.sv
// snoop_responder_pkg: shared cache constants, MESI encoding and snoop FSM states
package snoop_responder_pkg;
  localparam int TAG_W = 11;
  localparam int INDEX_W = 15;
  localparam int N_WAYS = 8;
  localparam int LINE_LSB = 6;
  localparam logic [2:0] OP_READ = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;
  localparam logic [2:0] OP_INVALIDATE = 3'd3;
  localparam logic [2:0] OP_RWIM = 3'd4;
  localparam logic [1:0] SR_NOHIT = 2'd0;
  localparam logic [1:0] SR_HIT = 2'd1;
  localparam logic [1:0] SR_HITM = 2'd2;
  localparam logic [2:0] L1_GETLINE = 3'd1;
  localparam logic [2:0] L1_INVALIDATELINE = 3'd3;
  typedef enum logic [1:0] {MESI_I = 2'd0, MESI_S = 2'd1, MESI_E = 2'd2, MESI_M = 2'd3} mesi_t;
  typedef enum logic [2:0] {ST_IDLE, ST_LOOKUP, ST_COMPARE, ST_GETL, ST_WB, ST_INVL, ST_UPD, ST_RESP} snoop_st_t;
endpackage

// File: rtl/snoop_way_match.sv
// snoop_way_match: combinational tag compare over all ways, lowest valid matching way wins
module snoop_way_match
  import snoop_responder_pkg::*;
#(
  parameter int NB_TAG = TAG_W,
  parameter int WAYS = N_WAYS
) (
  input  logic [WAYS*NB_TAG-1:0]   tags,
  input  logic [2*WAYS-1:0]        states,
  input  logic [NB_TAG-1:0]        tag,
  output logic                     hit,
  output logic [$clog2(WAYS)-1:0]  way,
  output mesi_t                    state,
  output logic                     multi_hit
);
  always_comb begin
    hit = 1'b0;
    way = '0;
    state = MESI_I;
    multi_hit = 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (tags[w*NB_TAG +: NB_TAG] == tag && states[2*w +: 2] != 2'(MESI_I)) begin
        multi_hit = multi_hit || hit;
        if (!hit) begin
          way = w[$clog2(WAYS)-1:0];
          state = mesi_t'(states[2*w +: 2]);
        end
        hit = 1'b1;
      end
  end
endmodule

// File: rtl/snoop_responder.sv
// snoop_responder: bus-side L2 snoop responder (lookup, L1 recall, writeback, MESI update)
module snoop_responder
  import snoop_responder_pkg::*;
#(
  parameter int NB_TAG = TAG_W,
  parameter int NB_INDEX = INDEX_W,
  parameter int WAYS = N_WAYS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     snoop_valid,
  output logic                     snoop_ready,
  input  logic [2:0]               snoop_op,
  input  logic [31:0]              snoop_addr,
  output logic                     ts_rd_en,
  output logic [NB_INDEX-1:0]      ts_index,
  input  logic [WAYS*NB_TAG-1:0]   ts_rd_tags,
  input  logic [WAYS*2-1:0]        ts_rd_states,
  output logic                     ts_wr_en,
  output logic [$clog2(WAYS)-1:0]  ts_wr_way,
  output logic [1:0]               ts_wr_state,
  output logic                     l1_msg_valid,
  output logic [2:0]               l1_msg,
  output logic [31:0]              l1_msg_addr,
  input  logic                     l1_msg_ack,
  output logic                     wb_valid,
  output logic [31:0]              wb_addr,
  input  logic                     wb_ready,
  output logic                     snoop_result_valid,
  output logic [1:0]               snoop_result,
  output logic                     protocol_err
);
  localparam int NB_WAY = $clog2(WAYS);
  snoop_st_t r_st, w_nxt, w_after_getl, w_after_wb, w_after_inv;
  logic [2:0] r_op;
  logic [31:0] r_addr, w_line;
  logic r_getl, r_wb, r_invl, r_upd;
  mesi_t r_new, w_ms;
  logic [NB_WAY-1:0] r_way, w_way;
  logic [1:0] r_res, r_last, w_res;
  logic w_hit, w_multi, w_rd, w_wr, w_inv, w_rwim, w_m, w_es;
  logic w_getl, w_wb, w_invl, w_upd, w_err, w_fg, w_fw, w_fi, w_fu;
  snoop_way_match #(.NB_TAG(NB_TAG), .WAYS(WAYS)) u_match (
    .tags(ts_rd_tags),
    .states(ts_rd_states),
    .tag(r_addr[31 -: NB_TAG]),
    .hit(w_hit),
    .way(w_way),
    .state(w_ms),
    .multi_hit(w_multi)
  );
  always_comb begin
    w_rd = r_op == OP_READ;
    w_wr = r_op == OP_WRITE;
    w_inv = r_op == OP_INVALIDATE;
    w_rwim = r_op == OP_RWIM;
    w_m = w_hit && w_ms == MESI_M;
    w_es = w_hit && (w_ms == MESI_E || w_ms == MESI_S);
    w_getl = w_m && (w_rd || w_rwim);
    w_wb = w_getl;
    w_invl = (w_rwim && w_hit) || (w_inv && w_es);
    w_upd = (w_rd && w_hit && w_ms != MESI_S) || w_invl;
    w_err = w_multi || (w_wr && w_hit) || (w_inv && w_m) || !(w_rd || w_wr || w_inv || w_rwim);
    w_res = (w_rd || w_rwim || w_inv) && w_hit ? (w_m ? SR_HITM : SR_HIT) : SR_NOHIT;
    w_fg = r_st == ST_COMPARE ? w_getl : r_getl;
    w_fw = r_st == ST_COMPARE ? w_wb : r_wb;
    w_fi = r_st == ST_COMPARE ? w_invl : r_invl;
    w_fu = r_st == ST_COMPARE ? w_upd : r_upd;
    w_after_inv = w_fu ? ST_UPD : ST_RESP;
    w_after_wb = w_fi ? ST_INVL : w_after_inv;
    w_after_getl = w_fw ? ST_WB : w_after_wb;
    w_nxt = r_st;
    case (r_st)
      ST_IDLE:    w_nxt = snoop_valid ? ST_LOOKUP : ST_IDLE;
      ST_LOOKUP:  w_nxt = ST_COMPARE;
      ST_COMPARE: w_nxt = w_fg ? ST_GETL : w_after_getl;
      ST_GETL:    w_nxt = l1_msg_ack ? w_after_getl : ST_GETL;
      ST_WB:      w_nxt = wb_ready ? w_after_wb : ST_WB;
      ST_INVL:    w_nxt = l1_msg_ack ? w_after_inv : ST_INVL;
      ST_UPD:     w_nxt = ST_RESP;
      default:    w_nxt = ST_IDLE;
    endcase
  end
  assign w_line = r_addr & ~32'h3f;
  assign snoop_ready = r_st == ST_IDLE;
  assign ts_rd_en = r_st == ST_LOOKUP;
  assign ts_index = r_addr[LINE_LSB +: NB_INDEX];
  assign ts_wr_en = r_st == ST_UPD;
  assign ts_wr_way = ts_wr_en ? r_way : '0;
  assign ts_wr_state = ts_wr_en ? r_new : MESI_I;
  assign l1_msg_valid = r_st == ST_GETL || r_st == ST_INVL;
  assign l1_msg = r_st == ST_GETL ? L1_GETLINE : r_st == ST_INVL ? L1_INVALIDATELINE : 3'd0;
  assign l1_msg_addr = l1_msg_valid ? w_line : 32'd0;
  assign wb_valid = r_st == ST_WB;
  assign wb_addr = wb_valid ? w_line : 32'd0;
  assign snoop_result_valid = r_st == ST_RESP;
  assign snoop_result = snoop_result_valid ? r_res : r_last;
  assign protocol_err = r_st == ST_COMPARE && w_err;
  always_ff @(posedge clk)
    if (rst) begin
      r_st <= ST_IDLE;
      r_op <= '0;
      r_addr <= '0;
      r_getl <= 1'b0;
      r_wb <= 1'b0;
      r_invl <= 1'b0;
      r_upd <= 1'b0;
      r_new <= MESI_I;
      r_way <= '0;
      r_res <= SR_NOHIT;
      r_last <= SR_NOHIT;
    end else begin
      r_st <= w_nxt;
      if (r_st == ST_IDLE && snoop_valid) begin
        r_op <= snoop_op;
        r_addr <= snoop_addr;
      end
      if (r_st == ST_COMPARE) begin
        r_getl <= w_getl;
        r_wb <= w_wb;
        r_invl <= w_invl;
        r_upd <= w_upd;
        r_new <= w_rd ? MESI_S : MESI_I;
        r_way <= w_way;
        r_res <= w_res;
      end
      if (r_st == ST_RESP) r_last <= r_res;
    end
endmodule
